// File: rtl/frv_gpr_wb_arbiter.sv
// Arbitrates the single GPR write port between the in-order writeback stage and
// a long-latency unit whose results are buffered in a small FIFO until the port is free.
module frv_gpr_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            wb_stall,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_wdata,
  output logic            lu_ready,
  output logic            gpr_wen,
  output logic [4:0]      gpr_rd,
  output logic [XLEN-1:0] gpr_wdata,
  output logic [31:0]     pend_mask
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  LIMIT_C  = SC_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_HEAD,
    GNT_BYPASS
  } gnt_e;

  logic [4:0]            r_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]       r_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_vld;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [SC_W-1:0]       r_starve;

  logic                  w_empty;
  logic                  w_starve_mode;
  logic                  w_wb_req;
  logic                  w_lu_live;
  logic                  w_push;
  logic                  w_pop;
  gnt_e                  w_grant;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [SC_W-1:0]       w_starve_nxt;
  logic [PTR_W-1:0]      w_head_inc;
  logic [PTR_W-1:0]      w_tail_inc;
  logic [31:0]           w_mask;

  assign w_empty       = (r_count == '0);
  assign w_starve_mode = !w_empty && (r_starve == LIMIT_C);
  assign w_wb_req      = wb_valid && (|wb_rd);

  // Readiness uses only the registered count, so a full FIFO refuses even while it pops.
  assign lu_ready  = (r_count != DEPTH_C);
  assign w_lu_live = lu_valid && lu_ready && (|lu_rd);
  assign wb_stall  = w_starve_mode;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_grant = GNT_NONE;
    if (w_starve_mode)        w_grant = GNT_HEAD;
    else if (w_wb_req)        w_grant = GNT_WB;
    else if (!w_empty)        w_grant = GNT_HEAD;
    else if (w_lu_live)       w_grant = GNT_BYPASS;
  end

  assign w_pop  = (w_grant == GNT_HEAD);
  assign w_push = w_lu_live && (w_grant != GNT_BYPASS);

  always_comb begin
    gpr_wen   = 1'b0;
    gpr_rd    = '0;
    gpr_wdata = '0;
    case (w_grant)
      GNT_WB: begin
        gpr_wen   = 1'b1;
        gpr_rd    = wb_rd;
        gpr_wdata = wb_wdata;
      end
      GNT_HEAD: begin
        gpr_wen   = 1'b1;
        gpr_rd    = r_rd[r_head];
        gpr_wdata = r_data[r_head];
      end
      GNT_BYPASS: begin
        gpr_wen   = 1'b1;
        gpr_rd    = lu_rd;
        gpr_wdata = lu_wdata;
      end
      default: begin
        gpr_wen = 1'b0;
      end
    endcase
  end

  assign w_head_inc = (r_head == LAST_PTR) ? '0 : r_head + PTR_W'(1);
  assign w_tail_inc = (r_tail == LAST_PTR) ? '0 : r_tail + PTR_W'(1);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  // The age counter tracks how long the current head has lost to writeback.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || (w_count_nxt == '0))
      w_starve_nxt = '0;
    else if ((w_grant == GNT_WB) && !w_empty && (r_starve != LIMIT_C))
      w_starve_nxt = r_starve + SC_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_vld    <= '0;
    end else begin
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      if (w_pop) begin
        r_head        <= w_head_inc;
        r_vld[r_head] <= 1'b0;
      end
      if (w_push) begin
        r_tail        <= w_tail_inc;
        r_vld[r_tail] <= 1'b1;
      end
    end
  end

  // NOTE: the entry storage is not reset; r_vld alone says which slots hold live data.
  always_ff @(posedge g_clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= lu_rd;
      r_data[r_tail] <= lu_wdata;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_vld[i]) w_mask[r_rd[i]] = 1'b1;
    end
    w_mask[0] = 1'b0;
  end

  assign pend_mask = w_mask;

endmodule

// File: tb/tb_frv_gpr_wb_arbiter.sv
// Bench for frv_gpr_wb_arbiter: a queue-based reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_frv_gpr_wb_arbiter;

  localparam int XLEN         = 32;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic            g_clk = 1'b0;
  logic            g_reset;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_stall;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_wdata;
  logic            lu_ready;
  logic            gpr_wen;
  logic [4:0]      gpr_rd;
  logic [XLEN-1:0] gpr_wdata;
  logic [31:0]     pend_mask;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  frv_gpr_wb_arbiter #(
    .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
    .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata), .pend_mask(pend_mask)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending results and the age of the current head.
  logic [4:0]      m_rd [$];
  logic [XLEN-1:0] m_d  [$];
  int              m_age = 0;

  always @(negedge g_clk) begin
    if (!done) begin
      bit          e_stall, e_ready, e_wen, take_head, bypass, wb_req;
      logic [4:0]  e_rd;
      logic [XLEN-1:0] e_d;
      logic [31:0] e_mask;
      int          size_before;

      if (g_reset) begin
        m_rd.delete();
        m_d.delete();
        m_age = 0;
      end

      size_before = m_rd.size();
      e_stall = (size_before > 0) && (m_age == STARVE_LIMIT);
      e_ready = size_before < FIFO_DEPTH;
      e_mask  = 32'h0;
      foreach (m_rd[i]) e_mask[m_rd[i]] = 1'b1;
      wb_req  = wb_valid && (wb_rd != 5'd0);

      take_head = 1'b0;
      bypass    = 1'b0;
      e_wen     = 1'b1;
      e_rd      = 5'd0;
      e_d       = '0;
      if (e_stall || (!wb_req && size_before > 0)) begin
        take_head = 1'b1;
        e_rd = m_rd[0];
        e_d  = m_d[0];
      end else if (wb_req) begin
        e_rd = wb_rd;
        e_d  = wb_wdata;
      end else if (lu_valid && lu_rd != 5'd0) begin
        bypass = 1'b1;
        e_rd = lu_rd;
        e_d  = lu_wdata;
      end else begin
        e_wen = 1'b0;
      end

      check("wb_stall", 64'(wb_stall), 64'(e_stall));
      check("lu_ready", 64'(lu_ready), 64'(e_ready));
      check("pend_mask", 64'(pend_mask), 64'(e_mask));
      check("gpr_wen", 64'(gpr_wen), 64'(e_wen));
      if (e_wen) begin
        check("gpr_rd", 64'(gpr_rd), 64'(e_rd));
        check("gpr_wdata", 64'(gpr_wdata), 64'(e_d));
      end

      if (!g_reset) begin
        if (take_head) begin
          void'(m_rd.pop_front());
          void'(m_d.pop_front());
        end
        if (lu_valid && e_ready && lu_rd != 5'd0 && !bypass) begin
          m_rd.push_back(lu_rd);
          m_d.push_back(lu_wdata);
        end
        if (take_head || m_rd.size() == 0) m_age = 0;
        else if (wb_req && !e_stall && size_before > 0 && m_age < STARVE_LIMIT) m_age++;
      end
    end
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic drv_wb(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    wb_valid = v;
    wb_rd    = rd;
    wb_wdata = d;
  endtask

  task automatic drv_lu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    lu_valid = v;
    lu_rd    = rd;
    lu_wdata = d;
  endtask

  initial begin
    g_reset = 1'b1;
    drv_wb(1'b0, 5'd0, '0);
    drv_lu(1'b0, 5'd0, '0);

    // Reset / idle
    step(); step();
    check("rst_stall", 64'(wb_stall), 64'd0);
    check("rst_wen", 64'(gpr_wen), 64'd0);
    check("rst_mask", 64'(pend_mask), 64'd0);
    check("rst_ready", 64'(lu_ready), 64'd1);
    g_reset = 1'b0;
    step();
    drv_wb(1'b1, 5'd5, 32'h11);
    #1;
    check("wb_wen", 64'(gpr_wen), 64'd1);
    check("wb_rd", 64'(gpr_rd), 64'd5);
    check("wb_data", 64'(gpr_wdata), 64'h11);

    // Bypass
    step();
    drv_wb(1'b0, 5'd0, '0);
    drv_lu(1'b1, 5'd7, 32'hABCD);
    #1;
    check("byp_wen", 64'(gpr_wen), 64'd1);
    check("byp_rd", 64'(gpr_rd), 64'd7);
    check("byp_data", 64'(gpr_wdata), 64'hABCD);
    check("byp_mask", 64'(pend_mask), 64'd0);
    step();
    drv_lu(1'b0, 5'd0, '0);
    #1;
    check("byp_mask_next", 64'(pend_mask), 64'd0);

    // Buffering
    step();
    drv_wb(1'b1, 5'd3, 32'h33);
    drv_lu(1'b1, 5'd9, 32'h99);
    #1;
    check("buf_wb_rd", 64'(gpr_rd), 64'd3);
    step();
    drv_wb(1'b0, 5'd0, '0);
    drv_lu(1'b0, 5'd0, '0);
    #1;
    check("buf_mask_set", 64'(pend_mask), 64'h200);
    check("buf_wen", 64'(gpr_wen), 64'd1);
    check("buf_rd", 64'(gpr_rd), 64'd9);
    check("buf_data", 64'(gpr_wdata), 64'h99);
    step();
    check("buf_mask_clr", 64'(pend_mask), 64'd0);

    // Full FIFO
    step();
    drv_wb(1'b1, 5'd1, 32'h100);
    drv_lu(1'b1, 5'd10, 32'hA0);
    step();
    drv_wb(1'b1, 5'd2, 32'h200);
    drv_lu(1'b1, 5'd11, 32'hB0);
    step();
    drv_wb(1'b1, 5'd3, 32'h300);
    drv_lu(1'b1, 5'd13, 32'hD0);
    #1;
    check("full_ready", 64'(lu_ready), 64'd0);
    check("full_mask", 64'(pend_mask), 64'h0C00);
    step();
    drv_wb(1'b0, 5'd0, '0);
    drv_lu(1'b0, 5'd0, '0);
    #1;
    check("drain0_rd", 64'(gpr_rd), 64'd10);
    check("drain0_data", 64'(gpr_wdata), 64'hA0);
    step();
    check("drain1_rd", 64'(gpr_rd), 64'd11);
    check("drain1_data", 64'(gpr_wdata), 64'hB0);
    step();
    check("drain_done", 64'(gpr_wen), 64'd0);

    // Starvation
    step();
    drv_wb(1'b1, 5'd4, 32'h400);
    drv_lu(1'b1, 5'd12, 32'h12);
    for (int i = 1; i <= 4; i++) begin
      step();
      drv_lu(1'b0, 5'd0, '0);
      drv_wb(1'b1, 5'(4 + i), 32'(i));
      #1;
      check("starve_wait_stall", 64'(wb_stall), 64'd0);
      check("starve_wait_rd", 64'(gpr_rd), 64'(4 + i));
    end
    step();
    drv_wb(1'b1, 5'd20, 32'h2020);
    #1;
    check("starve_stall", 64'(wb_stall), 64'd1);
    check("starve_rd", 64'(gpr_rd), 64'd12);
    check("starve_data", 64'(gpr_wdata), 64'h12);
    step();
    drv_lu(1'b1, 5'd14, 32'h14);
    #1;
    check("held_stall", 64'(wb_stall), 64'd0);
    check("held_rd", 64'(gpr_rd), 64'd20);
    check("held_data", 64'(gpr_wdata), 64'h2020);
    for (int i = 1; i <= 4; i++) begin
      step();
      drv_lu(1'b0, 5'd0, '0);
      drv_wb(1'b1, 5'(20 + i), 32'(i));
      #1;
      check("restart_stall", 64'(wb_stall), 64'd0);
    end
    step();
    drv_wb(1'b1, 5'd25, 32'h2525);
    #1;
    check("restart_stall_hit", 64'(wb_stall), 64'd1);
    check("restart_rd", 64'(gpr_rd), 64'd14);
    step();
    check("restart_held_rd", 64'(gpr_rd), 64'd25);

    // Misc edges
    step();
    drv_wb(1'b0, 5'd0, '0);
    drv_lu(1'b1, 5'd0, 32'hDEAD);
    #1;
    check("x0_lu_wen", 64'(gpr_wen), 64'd0);
    check("x0_lu_ready", 64'(lu_ready), 64'd1);
    step();
    drv_lu(1'b0, 5'd0, '0);
    drv_wb(1'b1, 5'd0, 32'hBEEF);
    #1;
    check("x0_lu_mask", 64'(pend_mask), 64'd0);
    check("x0_wb_wen", 64'(gpr_wen), 64'd0);

    // Reset with entries buffered
    step();
    drv_wb(1'b1, 5'd1, 32'h1);
    drv_lu(1'b1, 5'd15, 32'h15);
    step();
    drv_wb(1'b1, 5'd2, 32'h2);
    drv_lu(1'b1, 5'd16, 32'h16);
    step();
    drv_wb(1'b1, 5'd3, 32'h3);
    drv_lu(1'b0, 5'd0, '0);
    #1;
    check("pre_rst_mask", 64'(pend_mask), 64'h18000);
    check("pre_rst_ready", 64'(lu_ready), 64'd0);
    g_reset = 1'b1;
    #1;
    check("mid_rst_mask", 64'(pend_mask), 64'd0);
    check("mid_rst_ready", 64'(lu_ready), 64'd1);
    check("mid_rst_stall", 64'(wb_stall), 64'd0);
    check("mid_rst_rd", 64'(gpr_rd), 64'd3);
    drv_wb(1'b0, 5'd0, '0);
    step(); step();
    g_reset = 1'b0;
    #1;
    check("post_rst_wen", 64'(gpr_wen), 64'd0);
    check("post_rst_mask", 64'(pend_mask), 64'd0);
    step();
    check("post_rst_wen2", 64'(gpr_wen), 64'd0);

    step(); step();
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
